// File: rtl/beep_mixer.sv
// ---------------------------------------------------------------------------
// beep_mixer
//
// Multi-channel square-wave tone generator with per-side first-order
// sigma-delta mixing, intended to drive RC-filtered 1-bit speaker pins.
//
// Every channel owns a half-period register (PERIOD), a running flag (EN),
// left/right pan enables, an optional auto-stop toggle budget (DUR), a
// down-counter (CNT) and the square-wave level (SQ). A shared prescaler
// produces one tone tick every PRESCALE clocks. On each tick a running
// channel either counts down, or toggles SQ and reloads CNT from PERIOD.
//
// The mixer counts the channels whose wave is high on each side and feeds
// that count into an accumulator. The output goes high whenever the
// accumulator crosses CHANNELS, so the 1-density of the output equals
// (active channels) / CHANNELS.
//
// Ports:
//   CLK    in   1                   system clock, all logic on posedge
//   RST    in   1                   synchronous reset, active-high
//   WE     in   1                   register write strobe, one CLK per write
//   ADDR   in   $clog2(CHANNELS)+1  {channel index, reg select};
//                                   bit0=0 -> PERIOD, bit0=1 -> CTRL
//   WDATA  in   16                  write data
//                                   CTRL: [0]=EN [1]=PAN_L [2]=PAN_R [15:8]=DUR
//   BUSY   out  CHANNELS            per-channel EN state
//   OUTL   out  1                   left sigma-delta stream, registered
//   OUTR   out  1                   right sigma-delta stream, registered
// ---------------------------------------------------------------------------
module beep_mixer #(
  parameter int CHANNELS = 4,
  parameter int PERIOD_W = 12,
  parameter int PRESCALE = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        WE,
  input  logic [$clog2(CHANNELS):0]   ADDR,
  input  logic [15:0]                 WDATA,
  output logic [CHANNELS-1:0]         BUSY,
  output logic                        OUTL,
  output logic                        OUTR
);

  localparam int ADDR_W = $clog2(CHANNELS) + 1;
  localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SUM_W  = $clog2(CHANNELS + 1);
  localparam int ACC_W  = SUM_W + 1;

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [ACC_W-1:0] ACC_FULL = ACC_W'(CHANNELS);

  // Complete architectural state of one tone channel.
  typedef struct packed {
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] cnt;
    logic [7:0]          dur;
    logic                en;
    logic                pan_l;
    logic                pan_r;
    logic                sq;
  } chan_t;

  logic [PS_W-1:0]     r_ps;
  logic                w_tick;

  logic [ADDR_W-1:0]   w_wr_idx;
  logic [CHANNELS-1:0] w_per_we;
  logic [CHANNELS-1:0] w_ctl_we;

  chan_t               r_ch     [CHANNELS];
  chan_t               w_ch_nxt [CHANNELS];

  logic [SUM_W-1:0]    w_sum_l;
  logic [SUM_W-1:0]    w_sum_r;
  logic [ACC_W-1:0]    r_acc_l;
  logic [ACC_W-1:0]    r_acc_r;
  logic [ACC_W-1:0]    w_next_l;
  logic [ACC_W-1:0]    w_next_r;
  logic                r_outl;
  logic                r_outr;

  // Collects WDATA bits that no field consumes when PERIOD_W is small.
  logic                w_unused;
  assign w_unused = ^WDATA;

  // -------------------------------------------------------------------------
  // Prescaler: one tick every PRESCALE clocks; with PRESCALE=1 the counter
  // sits at 0 and every cycle is a tick. Register writes never disturb it.
  // -------------------------------------------------------------------------
  assign w_tick = (r_ps == PS_LAST);

  // NOTE: clocked state is always assigned with <= so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ps <= '0;
    end else if (w_tick) begin
      r_ps <= '0;
    end else begin
      r_ps <= r_ps + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Write decode. An index outside 0..CHANNELS-1 matches no channel, so such
  // writes fall through with no effect.
  // -------------------------------------------------------------------------
  assign w_wr_idx = ADDR >> 1;

  // NOTE: every signal driven from always_comb gets a default at the top of
  // the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_per_we = '0;
    w_ctl_we = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_per_we[c] = WE && !ADDR[0] && (w_wr_idx == ADDR_W'(c));
      w_ctl_we[c] = WE &&  ADDR[0] && (w_wr_idx == ADDR_W'(c));
    end
  end

  // -------------------------------------------------------------------------
  // Channel next-state.
  // A CTRL write takes precedence over a coincident tick for that channel.
  // A PERIOD write only updates the register: a reload in the same cycle
  // still copies the old PERIOD because it reads r_ch, not w_ch_nxt.
  // -------------------------------------------------------------------------
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_ch_nxt[c] = r_ch[c];

      if (w_per_we[c]) begin
        w_ch_nxt[c].period = WDATA[PERIOD_W-1:0];
      end

      if (w_ctl_we[c]) begin
        w_ch_nxt[c].en    = WDATA[0];
        w_ch_nxt[c].pan_l = WDATA[1];
        w_ch_nxt[c].pan_r = WDATA[2];
        w_ch_nxt[c].sq    = 1'b0;
        if (WDATA[0]) begin
          // (Re)start: phase begins at a full half-period with SQ low.
          w_ch_nxt[c].cnt = r_ch[c].period;
          w_ch_nxt[c].dur = WDATA[15:8];
        end
      end else if (w_tick && r_ch[c].en) begin
        if (r_ch[c].cnt == '0) begin
          w_ch_nxt[c].cnt = r_ch[c].period;
          if (r_ch[c].dur == 8'd1) begin
            // The toggle that would exhaust the budget stops the tone instead.
            w_ch_nxt[c].dur = '0;
            w_ch_nxt[c].en  = 1'b0;
            w_ch_nxt[c].sq  = 1'b0;
          end else begin
            w_ch_nxt[c].sq = ~r_ch[c].sq;
            // DUR=0 means unlimited; only a live budget counts down.
            if (r_ch[c].dur != '0) begin
              w_ch_nxt[c].dur = r_ch[c].dur - 8'd1;
            end
          end
        end else begin
          w_ch_nxt[c].cnt = r_ch[c].cnt - 1'b1;
        end
      end
    end
  end

  // NOTE: the channel array is a handful of flops rather than a RAM, so it
  // is cleared by reset like any other register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_ch[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_ch[c] <= w_ch_nxt[c];
      end
    end
  end

  always_comb begin
    BUSY = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      BUSY[c] = r_ch[c].en;
    end
  end

  // -------------------------------------------------------------------------
  // Mixer: runs every clock from the registered channel state, giving exactly
  // one clock of latency from SQ to OUTL/OUTR.
  // -------------------------------------------------------------------------
  always_comb begin
    w_sum_l = '0;
    w_sum_r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_sum_l = w_sum_l + SUM_W'(r_ch[c].en & r_ch[c].pan_l & r_ch[c].sq);
      w_sum_r = w_sum_r + SUM_W'(r_ch[c].en & r_ch[c].pan_r & r_ch[c].sq);
    end
  end

  // The accumulator stays below CHANNELS, so ACC + SUM never exceeds
  // 2*CHANNELS-1, which fits ACC_W bits.
  assign w_next_l = r_acc_l + ACC_W'(w_sum_l);
  assign w_next_r = r_acc_r + ACC_W'(w_sum_r);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_acc_l <= '0;
      r_acc_r <= '0;
      r_outl  <= 1'b0;
      r_outr  <= 1'b0;
    end else begin
      if (w_next_l >= ACC_FULL) begin
        r_outl  <= 1'b1;
        r_acc_l <= w_next_l - ACC_FULL;
      end else begin
        r_outl  <= 1'b0;
        r_acc_l <= w_next_l;
      end

      if (w_next_r >= ACC_FULL) begin
        r_outr  <= 1'b1;
        r_acc_r <= w_next_r - ACC_FULL;
      end else begin
        r_outr  <= 1'b0;
        r_acc_r <= w_next_r;
      end
    end
  end

  assign OUTL = r_outl;
  assign OUTR = r_outr;

endmodule

// File: tb/tb_beep_mixer.sv
// ---------------------------------------------------------------------------
// tb_beep_mixer
//
// Self-checking bench for beep_mixer (CHANNELS=4, PERIOD_W=12, PRESCALE=2).
// A behavioural model tracks each channel as "ticks until next toggle" and
// "toggles still allowed", and derives each sigma-delta bit from the running
// total of channel-high counts: the output is 1 exactly when that total
// crosses another multiple of CHANNELS. Directed scenarios pin the model
// with hand-computed literals; a randomized phase then exercises the rest.
// ---------------------------------------------------------------------------
module tb_beep_mixer;

  localparam int CH = 4;
  localparam int PW = 12;
  localparam int PS = 2;
  localparam int AW = $clog2(CH) + 1;

  logic          CLK   = 1'b0;
  logic          RST   = 1'b1;
  logic          WE    = 1'b0;
  logic [AW-1:0] ADDR  = '0;
  logic [15:0]   WDATA = '0;
  logic [CH-1:0] BUSY;
  logic          OUTL;
  logic          OUTR;

  beep_mixer #(
    .CHANNELS (CH),
    .PERIOD_W (PW),
    .PRESCALE (PS)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .WE    (WE),
    .ADDR  (ADDR),
    .WDATA (WDATA),
    .BUSY  (BUSY),
    .OUTL  (OUTL),
    .OUTR  (OUTR)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_mis = 0;

  // -------------------------------------------------------------------------
  // Behavioural model
  // -------------------------------------------------------------------------
  bit     m_valid = 1'b0;
  int     m_ps;
  bit     m_en  [CH];
  bit     m_pl  [CH];
  bit     m_pr  [CH];
  bit     m_sq  [CH];
  int     m_per [CH];
  int     m_rem [CH];   // ticks until the next toggle event
  int     m_left[CH];   // toggles still allowed, -1 = unlimited
  longint m_tot_l;
  longint m_tot_r;
  bit     m_outl;
  bit     m_outr;

  always @(posedge CLK) begin : model
    int sl;
    int sr;
    int wch;
    bit tick;
    if (RST) begin
      m_valid = 1'b1;
      m_ps    = 0;
      m_tot_l = 0;
      m_tot_r = 0;
      m_outl  = 1'b0;
      m_outr  = 1'b0;
      for (int c = 0; c < CH; c++) begin
        m_en[c] = 1'b0; m_pl[c] = 1'b0; m_pr[c] = 1'b0; m_sq[c] = 1'b0;
        m_per[c] = 0; m_rem[c] = 0; m_left[c] = -1;
      end
    end else begin
      sl = 0;
      sr = 0;
      for (int c = 0; c < CH; c++) begin
        if (m_en[c] && m_sq[c]) begin
          if (m_pl[c]) sl++;
          if (m_pr[c]) sr++;
        end
      end
      m_outl  = ((m_tot_l + sl) / CH) != (m_tot_l / CH);
      m_outr  = ((m_tot_r + sr) / CH) != (m_tot_r / CH);
      m_tot_l = m_tot_l + sl;
      m_tot_r = m_tot_r + sr;

      tick = (m_ps == PS - 1);
      m_ps = tick ? 0 : m_ps + 1;
      wch  = int'(ADDR) / 2;

      for (int c = 0; c < CH; c++) begin
        if (WE && ADDR[0] && wch == c) begin
          m_en[c] = WDATA[0];
          m_pl[c] = WDATA[1];
          m_pr[c] = WDATA[2];
          m_sq[c] = 1'b0;
          if (WDATA[0]) begin
            m_rem[c]  = m_per[c] + 1;
            m_left[c] = (WDATA[15:8] == 8'd0) ? -1 : int'(WDATA[15:8]) - 1;
          end
        end else if (tick && m_en[c]) begin
          m_rem[c]--;
          if (m_rem[c] == 0) begin
            if (m_left[c] == 0) begin
              m_en[c] = 1'b0;
              m_sq[c] = 1'b0;
            end else begin
              m_sq[c] = !m_sq[c];
              if (m_left[c] > 0) m_left[c]--;
              m_rem[c] = m_per[c] + 1;
            end
          end
        end
      end

      if (WE && !ADDR[0] && wch < CH) m_per[wch] = int'(WDATA) % (1 << PW);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    logic [CH-1:0] mb;
    if (m_valid) begin
      mb = '0;
      for (int c = 0; c < CH; c++) mb[c] = m_en[c];
      n_vec++;
      if (BUSY !== mb || OUTL !== m_outl || OUTR !== m_outr) begin
        n_mis++;
        $display("FAIL model_cmp t=%0t BUSY dut=%h model=%h OUTL dut=%b model=%b OUTR dut=%b model=%b",
                 $time, BUSY, mb, OUTL, m_outl, OUTR, m_outr);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_wr(input int ch, input bit sel, input logic [15:0] data);
    WE    = 1'b1;
    ADDR  = AW'(ch * 2 + int'(sel));
    WDATA = data;
  endtask

  task automatic do_reset();
    WE  = 1'b0;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  // Wait until the current cycle is the first of a prescaler window.
  task automatic align();
    WE = 1'b0;
    while (m_ps != 0) @(negedge CLK);
  endtask

  function automatic logic [31:0] pick(input logic [127:0] v, input int a, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = v[a + i];
    return r;
  endfunction

  function automatic int ones(input logic [127:0] v, input int a, input int b);
    int r;
    r = 0;
    for (int i = a; i <= b; i++) if (v[i] === 1'b1) r++;
    return r;
  endfunction

  logic [127:0]  s_l;
  logic [127:0]  s_r;
  logic [CH-1:0] s_b [128];

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int bad;
    int ch;
    bit sel;
    logic [15:0] d;
    logic [7:0]  dur;

    // Reset state and idle behaviour.
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    check("busy_after_reset", 32'(BUSY), 32'h0);
    bad = 0;
    for (int j = 0; j < 100; j++) begin
      if (BUSY !== '0 || OUTL !== 1'b0 || OUTR !== 1'b0) bad++;
      @(negedge CLK);
    end
    check("idle_100_cycles", bad, 0);

    // Writes while reset is held are ignored.
    RST = 1'b1;
    set_wr(0, 1'b0, 16'd3);     @(negedge CLK);
    set_wr(0, 1'b1, 16'h0007);  @(negedge CLK);
    set_wr(3, 1'b1, 16'h0407);  @(negedge CLK);
    WE  = 1'b0;
    RST = 1'b0;
    bad = 0;
    for (int j = 0; j < 40; j++) begin
      if (BUSY !== '0 || OUTL !== 1'b0 || OUTR !== 1'b0) bad++;
      @(negedge CLK);
    end
    check("writes_in_reset_ignored", bad, 0);

    // Tone timing on ch0, then stop mid-tone.
    do_reset();
    set_wr(0, 1'b0, 16'd3); @(negedge CLK);
    align();
    for (int j = 0; j <= 100; j++) begin
      s_l[j] = OUTL; s_r[j] = OUTR; s_b[j] = BUSY;
      if (j == 0)       set_wr(0, 1'b1, 16'h0007);
      else if (j == 74) set_wr(0, 1'b1, 16'h0000);
      else              WE = 1'b0;
      @(negedge CLK);
    end
    WE = 1'b0;
    check("tone_busy_at_write", 32'(s_b[0]), 32'h0);
    check("tone_busy_next",     32'(s_b[1]), 32'h1);
    check("tone_L_first16",     pick(s_l, 1, 16), 32'h8800);
    check("tone_R_first16",     pick(s_r, 1, 16), 32'h8800);
    check("tone_L_ones64",      ones(s_l, 1, 64), 8);
    check("stop_busy_before",   32'(s_b[74]), 32'h1);
    check("stop_busy_after",    32'(s_b[75]), 32'h0);
    check("stop_drained",       ones(s_l, 80, 100), 0);

    // Panning and full scale: four left-only channels in one window.
    do_reset();
    for (int c = 0; c < CH; c++) begin
      set_wr(c, 1'b0, 16'd3); @(negedge CLK);
    end
    align();
    for (int j = 0; j < 64; j++) begin
      s_l[j] = OUTL; s_r[j] = OUTR; s_b[j] = BUSY;
      if (j < CH) set_wr(j, 1'b1, 16'h0003);
      else        WE = 1'b0;
      @(negedge CLK);
    end
    WE = 1'b0;
    check("pan_busy_all",   32'(s_b[4]), 32'hF);
    check("pan_L_fullscale", pick(s_l, 9, 8), 32'hFC);
    check("pan_R_silent",   ones(s_r, 0, 63), 0);

    // Duration: DUR=4 gives three toggles, then the channel stops itself.
    do_reset();
    set_wr(2, 1'b0, 16'd0); @(negedge CLK);
    align();
    for (int j = 0; j <= 20; j++) begin
      s_l[j] = OUTL; s_r[j] = OUTR; s_b[j] = BUSY;
      if (j == 0) set_wr(2, 1'b1, 16'h0403);
      else        WE = 1'b0;
      @(negedge CLK);
    end
    WE = 1'b0;
    check("dur_busy_at_write", 32'(s_b[0]), 32'h0);
    check("dur_busy_next",     32'(s_b[1]), 32'h4);
    check("dur_busy_last",     32'(s_b[7]), 32'h4);
    check("dur_busy_stopped",  32'(s_b[8]), 32'h0);
    check("dur_L_quiet_early", ones(s_l, 0, 7), 0);
    check("dur_L_single_one",  32'(s_l[8]), 32'h1);
    check("dur_L_quiet_late",  ones(s_l, 9, 20), 0);

    // PERIOD write colliding with a reload: old value used once, then new.
    do_reset();
    set_wr(0, 1'b0, 16'd3); @(negedge CLK);
    align();
    for (int j = 0; j <= 45; j++) begin
      s_l[j] = OUTL; s_r[j] = OUTR; s_b[j] = BUSY;
      if (j == 0)      set_wr(0, 1'b1, 16'h0003);
      else if (j == 7) set_wr(0, 1'b0, 16'd9);
      else             WE = 1'b0;
      @(negedge CLK);
    end
    WE = 1'b0;
    check("reload_old_high_end", 32'(s_l[16]), 32'h1);
    check("reload_new_low_len",  ones(s_l, 17, 39), 0);
    check("reload_new_high",     32'(s_l[40]), 32'h1);

    // Randomized traffic, checked every cycle by the model.
    do_reset();
    for (int i = 0; i < 20000; i++) begin
      if (RST) RST = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
      else     RST = ($urandom_range(0, 499) == 0);
      WE  = ($urandom_range(0, 5) == 0);
      ch  = $urandom_range(0, CH - 1);
      sel = 1'($urandom_range(0, 1));
      if (!sel) begin
        d = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
      end else begin
        dur = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
        d   = {dur, 5'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0)};
      end
      ADDR  = AW'(ch * 2 + int'(sel));
      WDATA = d;
      @(negedge CLK);
    end
    WE  = 1'b0;
    RST = 1'b0;
    repeat (20) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
